// File: rtl/mte_block_sequencer.sv
// Byte-to-block front end for the MTE core: packs bytes MSB-first, pads short blocks,
// issues them to the core and returns results on a valid/ready port.
// Optional key-valid timeout is enabled by defining MTE_SEQ_TIMEOUT_EN.
module mte_block_sequencer #(
  parameter int         BLOCK_BYTES = 32,
  parameter int         CORE_LAT    = 1,
  parameter logic [7:0] PAD_BYTE    = 8'h30,
  parameter int         TIMEOUT_CYC = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [BLOCK_BYTES*8-1:0] cfg_key,
  input  logic                     cfg_sel,
  input  logic                     cfg_load,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  output logic [BLOCK_BYTES*8-1:0] core_key,
  output logic                     core_sel,
  output logic [BLOCK_BYTES*8-1:0] core_in,
  input  logic [BLOCK_BYTES*8-1:0] core_out,
  input  logic                     core_key_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BLOCK_BYTES*8-1:0] out_data,
  output logic [5:0]               out_pad_cnt,
  output logic                     out_last,
  output logic                     busy,
  output logic                     err,
  output logic [1:0]               state_dbg
);

  localparam int BW = BLOCK_BYTES * 8;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  if (CORE_LAT < 1 || TIMEOUT_CYC < 1 || BLOCK_BYTES < 1 || BLOCK_BYTES > 63) begin : g_bad_param
    $error("mte_block_sequencer: illegal parameter value");
  end

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
  // valid-side data is held stable until that edge, ready never waits on valid.

  logic [1:0]    state;
  logic [5:0]    byte_cnt;
  logic [BW-9:0] shreg;
  logic [BW-1:0] block_q;
  logic [7:0]    wait_cnt;

  logic          accept;
  logic          close;
  logic          cfg_ok;
  logic [5:0]    next_cnt;
  logic [5:0]    pad;
  logic [BW-1:0] next_shreg;
  logic [BW-1:0] shifted;
  logic [BW-1:0] fill;
  logic [BW-1:0] next_block;

  assign in_ready  = (state == FILL);
  assign core_in   = block_q;
  assign busy      = !((state == FILL) && (byte_cnt == 6'd0));
  assign state_dbg = state;

  always_comb begin
    accept     = (state == FILL) && in_valid;
    next_cnt   = byte_cnt + 6'd1;
    next_shreg = {shreg, in_data};
    close      = accept && ((next_cnt == 6'(BLOCK_BYTES)) || in_last);
    pad        = 6'(BLOCK_BYTES) - next_cnt;
    // Received bytes sit at the bottom of the shift register; move them to the top.
    shifted    = next_shreg << {pad, 3'b000};
    fill       = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (6'(i) < pad) fill[i*8 +: 8] = PAD_BYTE;
    end
    next_block = shifted | fill;
    cfg_ok     = cfg_load && (state == FILL) && (byte_cnt == 6'd0) && !accept;
  end

`ifdef MTE_SEQ_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FILL;
      byte_cnt    <= 6'd0;
      shreg       <= '0;
      block_q     <= '0;
      core_key    <= {{(BW-1){1'b0}}, 1'b1};
      core_sel    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_pad_cnt <= 6'd0;
      out_last    <= 1'b0;
      wait_cnt    <= 8'd0;
`ifdef MTE_SEQ_TIMEOUT_EN
      to_cnt      <= 16'd0;
      err_q       <= 1'b0;
`endif
    end else begin
`ifdef MTE_SEQ_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      if (cfg_ok) begin
        core_key <= cfg_key;
        core_sel <= cfg_sel;
      end
      case (state)
        FILL: begin
          if (accept) begin
            if (close) begin
              block_q     <= next_block;
              out_pad_cnt <= pad;
              out_last    <= in_last;
              byte_cnt    <= 6'd0;
              state       <= ISSUE;
            end else begin
              shreg    <= next_shreg[BW-9:0];
              byte_cnt <= next_cnt;
            end
          end
        end
        ISSUE: begin
          if (core_key_valid) begin
            wait_cnt <= 8'(CORE_LAT - 1);
            state    <= WAIT;
`ifdef MTE_SEQ_TIMEOUT_EN
            to_cnt   <= 16'd0;
          end else if (to_cnt == 16'(TIMEOUT_CYC - 1)) begin
            // Key never became valid: drop the block and flag it.
            to_cnt   <= 16'd0;
            err_q    <= 1'b1;
            byte_cnt <= 6'd0;
            state    <= FILL;
          end else begin
            to_cnt <= to_cnt + 16'd1;
`endif
          end
        end
        WAIT: begin
          if (wait_cnt == 8'd0) begin
            out_data  <= core_out;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            byte_cnt  <= 6'd0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mte_block_sequencer.sv
// Directed bench for mte_block_sequencer: vector table of whole blocks plus
// hand-written sequences for stalls, config gating, mid-flight reset and timeout.
module tb_mte_block_sequencer;

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [255:0] cfg_key = '0;
  logic         cfg_sel = 1'b0;
  logic         cfg_load = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic [255:0] core_key;
  logic         core_sel;
  logic [255:0] core_in;
  logic [255:0] core_out = '0;
  logic         core_key_valid = 1'b1;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_data;
  logic [5:0]   out_pad_cnt;
  logic         out_last;
  logic         busy;
  logic         err;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] cur_key;
  logic         cur_sel;

  mte_block_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_key(cfg_key), .cfg_sel(cfg_sel), .cfg_load(cfg_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_key(core_key), .core_sel(core_sel), .core_in(core_in), .core_out(core_out),
    .core_key_valid(core_key_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pad_cnt(out_pad_cnt), .out_last(out_last),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // One-cycle core model.
  always @(posedge clock) core_out <= core_in ^ core_key ^ {256{core_sel}};

  typedef struct {
    string        name;
    logic [255:0] src;
    int           n;
    logic         last;
    logic [255:0] exp_block;
    logic [5:0]   exp_pad;
    logic         exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_out(input logic [255:0] blk);
    return blk ^ cur_key ^ {256{cur_sel}};
  endfunction

  task automatic send_bytes(input logic [255:0] src, input int n, input logic last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = src[255-8*i -: 8];
      in_last  = last && (i == n - 1);
      check("in_ready_fill", 256'(in_ready), 256'(1));
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat);
    int k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    check("latency", 256'(k), 256'(exp_lat));
  endtask

  task automatic check_out(input logic [255:0] blk, input logic [5:0] pad, input logic last);
    check("out_data", out_data, model_out(blk));
    check("out_pad_cnt", 256'(out_pad_cnt), 256'(pad));
    check("out_last", 256'(out_last), 256'(last));
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("out_valid_drop", 256'(out_valid), 256'(0));
    check("in_ready_back", 256'(in_ready), 256'(1));
    check("busy_idle", 256'(busy), 256'(0));
  endtask

  task automatic run_vec(input vec_t v);
    send_bytes(v.src, v.n, v.last);
    check({v.name, "_core_in"}, core_in, v.exp_block);
    check({v.name, "_in_ready"}, 256'(in_ready), 256'(0));
    wait_out(2);
    check_out(v.exp_block, v.exp_pad, v.exp_last);
    take_out();
  endtask

  task automatic check_reset_values();
    check("rst_core_key", core_key, 256'd1);
    check("rst_core_sel", 256'(core_sel), 256'(0));
    check("rst_core_in", core_in, 256'd0);
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_data", out_data, 256'd0);
    check("rst_out_pad", 256'(out_pad_cnt), 256'(0));
    check("rst_out_last", 256'(out_last), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_state", 256'(state_dbg), 256'(S_FILL));
  endtask

  initial begin
    logic [255:0] key_a;
    logic [255:0] key_b;
    logic [255:0] exp8;
    int err_cnt;
    int ov_cnt;

    key_a = {8{32'hdeadbeef}};
    key_b = {8{32'h0badf00d}};
    exp8  = {64'h0102030405060708, {24{8'h30}}};

    vecs[0] = '{"full32", 256'h4142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f60, 32, 1'b0,
                256'h4142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f60, 6'd0, 1'b0};
    vecs[1] = '{"hi_nl", {24'h48690a, 232'h0}, 3, 1'b1,
                256'h48690a_3030303030303030_3030303030303030_3030303030303030_3030303030, 6'd29, 1'b1};
    vecs[2] = '{"one_byte", {8'haa, 248'h0}, 1, 1'b1,
                256'haa_3030303030303030_3030303030303030_3030303030303030_30303030303030, 6'd31, 1'b1};
    vecs[3] = '{"full32_last", 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 32, 1'b1,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 6'd0, 1'b1};
    vecs[4] = '{"b31_last", {248'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8'h00}, 31, 1'b1,
                256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f30, 6'd1, 1'b1};

    // Clock/reset.
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check_reset_values();
    cur_key = 256'd1;
    cur_sel = 1'b0;

    // Config load while idle takes effect on the next edge.
    cfg_key = key_a; cfg_sel = 1'b1; cfg_load = 1'b1;
    @(posedge clock); #1;
    cfg_load = 1'b0;
    check("cfg_idle_key", core_key, key_a);
    check("cfg_idle_sel", 256'(core_sel), 256'(1));
    cur_key = key_a; cur_sel = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Key-valid stall in ISSUE.
    core_key_valid = 1'b0;
    send_bytes(vecs[1].src, vecs[1].n, vecs[1].last);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      check("stall_state", 256'(state_dbg), 256'(S_ISSUE));
      check("stall_in_ready", 256'(in_ready), 256'(0));
      check("stall_core_in", core_in, vecs[1].exp_block);
      check("stall_out_valid", 256'(out_valid), 256'(0));
    end
    core_key_valid = 1'b1;
    wait_out(2);
    check_out(vecs[1].exp_block, vecs[1].exp_pad, vecs[1].exp_last);

    // Output back-pressure: nothing consumed while the result waits.
    in_valid = 1'b1; in_data = 8'hee;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      check("bp_out_valid", 256'(out_valid), 256'(1));
      check("bp_out_data", out_data, model_out(vecs[1].exp_block));
      check("bp_in_ready", 256'(in_ready), 256'(0));
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp_release_busy", 256'(busy), 256'(0));
    check("bp_release_in_ready", 256'(in_ready), 256'(1));
    check("bp_release_out_valid", 256'(out_valid), 256'(0));

    // cfg_load mid-block is ignored; block finishes with the old key.
    send_bytes(256'h0102030405 << 216, 5, 1'b0);
    cfg_key = key_b; cfg_sel = 1'b0; cfg_load = 1'b1;
    @(posedge clock); #1;
    cfg_load = 1'b0;
    check("cfg_mid_key", core_key, key_a);
    check("cfg_mid_sel", 256'(core_sel), 256'(1));
    send_bytes(256'h060708 << 232, 3, 1'b1);
    check("cfg_mid_core_in", core_in, exp8);
    wait_out(2);
    check_out(exp8, 6'd24, 1'b1);
    take_out();
    cfg_load = 1'b1;
    @(posedge clock); #1;
    cfg_load = 1'b0;
    check("cfg_zero_key", core_key, key_b);
    check("cfg_zero_sel", 256'(core_sel), 256'(0));
    cur_key = key_b; cur_sel = 1'b0;

    // Reset asserted while in WAIT.
    send_bytes(256'h11223344 << 224, 4, 1'b1);
    @(posedge clock); #1;
    check("pre_reset_state", 256'(state_dbg), 256'(S_WAIT));
    reset_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge clock); #1;
    reset_n = 1'b1;
    cur_key = 256'd1; cur_sel = 1'b0;
    run_vec(vecs[0]);

    // Key-valid never arrives.
    core_key_valid = 1'b0;
    err_cnt = 0; ov_cnt = 0;
    send_bytes({8'h55, 248'h0}, 1, 1'b1);
    for (int c = 0; c < 80; c++) begin
      @(posedge clock); #1;
      if (err) err_cnt++;
      if (out_valid) ov_cnt++;
    end
    check("to_out_valid", 256'(ov_cnt), 256'(0));
`ifdef MTE_SEQ_TIMEOUT_EN
    check("to_err_pulses", 256'(err_cnt), 256'(1));
    check("to_state", 256'(state_dbg), 256'(S_FILL));
    check("to_busy", 256'(busy), 256'(0));
    core_key_valid = 1'b1;
`else
    check("to_err_pulses", 256'(err_cnt), 256'(0));
    check("to_state", 256'(state_dbg), 256'(S_ISSUE));
    core_key_valid = 1'b1;
    wait_out(2);
    check_out(vecs[2].exp_block ^ {8'haa ^ 8'h55, 248'h0}, 6'd31, 1'b1);
    take_out();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mte_block_sequencer.md
Name: mte_block_sequencer

Overview:
Front-end controller for the MTE encrypt/decrypt core. It accepts a byte stream with valid/ready handshaking and packs 32 bytes MSB-first into a 256-bit block, padding short final blocks with ASCII '0'. It holds the key and mode configuration, issues each block to the core, waits the core latency, and presents the result on a valid/ready output port. It sits between the text-ingest logic and the MTE instance, which it drives directly.

Parameters:
BLOCK_BYTES, 32, bytes per block; the block width is BLOCK_BYTES*8 = 256.
CORE_LAT, 1, core latency in cycles from stable core_in to valid core_out; must be at least 1.
PAD_BYTE, 8'h30, fill byte for short blocks (ASCII '0').
TIMEOUT_CYC, 64, key-valid wait limit; used only with MTE_SEQ_TIMEOUT_EN.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cfg_key  in  256  key to load
cfg_sel  in  1  mode to load: 0 encrypt, 1 decrypt
cfg_load  in  1  load request for cfg_key and cfg_sel
in_valid  in  1  byte valid
in_ready  out  1  byte accepted when in_valid and in_ready are both high
in_data  in  8  byte
in_last  in  1  last byte of the line; closes the block
core_key  out  256  key to MTE
core_sel  out  1  mode to MTE
core_in  out  256  block to MTE
core_out  in  256  MTE result
core_key_valid  in  1  MTE key-ready indication
out_valid  out  1  result valid
out_ready  in  1  result accepted
out_data  out  256  result block
out_pad_cnt  out  6  number of pad bytes in the block (0..31)
out_last  out  1  block was closed by in_last
busy  out  1  high in any state other than FILL with a zero byte count
err  out  1  one-cycle timeout pulse (only with MTE_SEQ_TIMEOUT_EN)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=FILL, byte_cnt=0.
  - core_key=256'b1, core_sel=0, core_in=0.
  - out_valid=0, out_data=0, out_pad_cnt=0, out_last=0, err=0.
  - in_ready=1 after release.
  - Any partial block is discarded.
- FILL state:
  - in_ready=1.
  - Accepted byte: shreg <= {shreg[247:0], in_data}; byte_cnt increments.
  - Block closes when byte_cnt reaches 32, or when in_last is high on an accepted byte.
  - On close, the block register takes (shreg shifted left by 8*pad) filled with PAD_BYTE in the low pad bytes, where pad = 32 - bytes received.
  - pad is latched into out_pad_cnt and in_last into out_last; state goes to ISSUE.
  - The first byte received always lands in bits [255:248].
  - A 32nd byte arriving with in_last gives pad=0 and out_last=1.
- cfg_load is honoured only in FILL with byte_cnt=0 and no byte accepted in the same cycle. core_key and core_sel update on the next edge. Otherwise cfg_load is ignored; it is not queued.
- ISSUE state:
  - in_ready=0; core_in=block.
  - If core_key_valid=1, go to WAIT with wait_cnt=CORE_LAT-1; otherwise remain in ISSUE.
- WAIT state:
  - core_in is held stable; wait_cnt decrements.
  - When wait_cnt=0: capture core_out into out_data, set out_valid=1, go to OUT.
- OUT state:
  - out_valid, out_data, out_pad_cnt and out_last are held stable until out_valid and out_ready are both high.
  - On that handshake: out_valid=0, byte_cnt=0, go to FILL.
  - in_ready=0 throughout; no overlap.
- Latency: with the last byte accepted at edge E0 and core_key_valid high, out_valid rises at edge E0+1+CORE_LAT.
- core_in, core_key and core_sel never change while in ISSUE or WAIT.
- Reset mid-operation in any state returns all outputs to their reset values immediately.

Optional Feature:
MTE_SEQ_TIMEOUT_EN:
- Defined: a counter runs while in ISSUE. If core_key_valid stays low for TIMEOUT_CYC consecutive cycles:
  - the block is dropped;
  - err pulses for 1 cycle;
  - state returns to FILL with byte_cnt=0 and no out_valid.
  - The counter clears on leaving ISSUE.
- Undefined: ISSUE waits indefinitely, and err is tied to 0.

Test Plan:
- Load cfg_key=1, cfg_sel=0; send 32 bytes 0x41..0x60 with no last -> core_in=0x4142...60, out_pad_cnt=0, out_last=0; with CORE_LAT=1, out_valid rises 2 edges after the 32nd byte.
- Send "Hi\n" (0x48,0x69,0x0A) with in_last on 0x0A -> core_in=0x48690A followed by 29 bytes of 0x30; out_pad_cnt=29, out_last=1.
- Hold core_key_valid=0 for 5 cycles at ISSUE -> state stays ISSUE, in_ready=0, core_in stable; raising core_key_valid gives out_valid CORE_LAT+1 edges later.
- Hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0, no bytes consumed; out_ready=1 gives in_ready=1 on the next cycle.
- cfg_load with a new key at byte_cnt=5 -> core_key unchanged; cfg_load at byte_cnt=0 -> core_key updated on the next edge.
- Assert reset_n=0 during WAIT -> all outputs return to reset values immediately; the next block sent is correct and unaffected. With MTE_SEQ_TIMEOUT_EN and core_key_valid=0 for 64 cycles -> err pulses once, no out_valid.
